mem_wb_pipe: RTL and testbench
==============================

# mem_wb_pipe

Pipeline block for the EX/MEM and MEM/WB boundaries of the TSC CPU. It latches EX results and runs the data-memory read/write handshake, freezing upstream stages while an access is outstanding. It drives `reg_write_mem`/`write_reg_mem` and `reg_write_wb`/`write_reg_wb`, which the forwarding unit consumes directly, together with the data values those forwarding selections pick.

## Interface
- `WORD_BITS`, 16, datapath width
- `REG_ID_BITS`, 2, register-id width (4 GPRs)
- `TIMEOUT_CYCLES`, 15, max WAIT cycles before abort; used only with the macro

- `clk` in 1: single clock; all state on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `ex_valid` in 1: EX holds a real instruction
- `ex_reg_write` in 1: EX instruction writes RF
- `ex_write_reg` in REG_ID_BITS: EX destination
- `ex_mem_read` / `ex_mem_write` in 1 each: load / store (mutually exclusive)
- `ex_alu_result` in WORD_BITS: ALU result or effective address
- `ex_store_data` in WORD_BITS: store data
- `mem_stall` out 1: freeze PC, IF/ID and ID/EX
- `d_addr` out WORD_BITS; `d_readM` out 1; `d_writeM` out 1; `d_data_out` out WORD_BITS
- `d_data_in` in WORD_BITS; `d_ack` in 1: single-cycle completion strobe
- `reg_write_mem` out 1; `write_reg_mem` out REG_ID_BITS; `mem_is_load` out 1; `fwd_data_mem` out WORD_BITS
- `reg_write_wb` out 1; `write_reg_wb` out REG_ID_BITS; `wb_data` out WORD_BITS
- `mem_error` out 1: sticky timeout flag (tied 0 without macro)

## Operation
- EX/MEM latch: loads on each edge where `mem_stall`=0. `ex_valid`=0 loads a bubble (valid=0, all controls 0). Holds when `mem_stall`=1.
- `reg_write_mem` = mem_valid & reg_write. `mem_is_load` = mem_valid & mem_read. `fwd_data_mem` = latched alu_result. A load's result cannot be forwarded from MEM; the hazard unit stalls on `mem_is_load`.
- FSM states:
  - IDLE: no access outstanding.
  - WAIT: access outstanding; `d_readM`/`d_writeM` high, `d_addr` = alu_result, `d_data_out` = store_data.
- Transitions:
  - Any latch load of a valid memory op enters WAIT.
  - WAIT with `d_ack`=1 completes; next state is WAIT if the newly loaded entry is a memory op, else IDLE.
- `mem_stall` = (state==WAIT) & ~`d_ack`.
- MEM/WB latch, every edge:
  - MEM entry completes (valid non-memory op, or WAIT with `d_ack`): WB takes the entry. `wb_data` = `d_data_in` for loads, alu_result otherwise.
  - Otherwise WB takes a bubble (`reg_write_wb`=0, `wb_data` held).
- Stores never set `reg_write_*`. `d_ack` in IDLE is ignored.
- Reset: both latches invalid, FSM IDLE, counter 0. Every output is 0, including memory strobes and `mem_error`. Reset asserted mid-access drops `d_readM`/`d_writeM` immediately and asynchronously.

## Timing
- Non-memory op: EX→MEM 1 cycle, MEM→WB 1 cycle, no stall.
- Memory op with `d_ack` in its first MEM cycle: no stall.
- Each cycle without `d_ack` adds exactly one stall cycle.
- Back-to-back memory ops: the second enters WAIT on the first's ack edge; no idle gap.
- WB-stage outputs are registered. MEM-stage outputs come straight from the EX/MEM latch. `mem_stall` is combinational from state and `d_ack`.

## Configuration
- `MEM_WB_TIMEOUT_EN` defined:
  - A 4-bit-capable counter (sized by `TIMEOUT_CYCLES`) counts WAIT cycles without ack.
  - On reaching `TIMEOUT_CYCLES`: strobes drop, the entry is discarded (WB bubble), `mem_error` sets sticky until reset, and the FSM returns to IDLE, releasing the stall.
- Undefined: WAIT persists indefinitely, no counter is built, `mem_error`=0.

## Structure
- Shared package `tsc_pipe_pkg`: `WORD_BITS`, `REG_ID_BITS`, FSM state enum (`MEM_IDLE`, `MEM_WAIT`), pipeline-entry struct (valid, reg_write, write_reg, mem_read, mem_write, alu_result, store_data).
- One sub-module, `mem_access_fsm`: state, timeout counter, strobe and `mem_stall` generation. Latches stay in the top.

## Test plan
- Reset: drive `reset_n`=0 with `d_ack`=1 → every output is 0; after release with `ex_valid`=0, `reg_write_mem`=`reg_write_wb`=0.
- ALU op to r2, result 0x1234: cycle 1 `reg_write_mem`=1, `write_reg_mem`=2, `fwd_data_mem`=0x1234; cycle 2 `reg_write_wb`=1, `wb_data`=0x1234, `mem_stall`=0 throughout.
- Load r1 from 0x0040, ack 3 cycles late, `d_data_in`=0xBEEF: `d_readM`=1 and `d_addr`=0x0040 for 4 cycles, `mem_stall`=1 for 3, next cycle `wb_data`=0xBEEF, `write_reg_wb`=1, WB bubbles during the wait.
- Store 0x00AA to 0x0010 then load from 0x0010, both immediate ack: `d_writeM` then `d_readM` on consecutive cycles, `mem_stall`=0, store never sets `reg_write_wb`.
- Reset during WAIT: `d_readM` falls without a clock edge, FSM is IDLE after release, and a late `d_ack` has no effect.
- With `MEM_WB_TIMEOUT_EN`, no ack: after 15 WAIT cycles strobes drop, `mem_error`=1, `mem_stall`=0, `reg_write_wb`=0; `mem_error` stays 1 until reset.

Source files
------------

// File: rtl/tsc_pipe_pkg.sv
// Shared types for the TSC CPU pipeline: datapath widths, the data-memory
// access state enum and the EX/MEM pipeline-entry record.
package tsc_pipe_pkg;

  localparam int unsigned WORD_BITS   = 16;
  localparam int unsigned REG_ID_BITS = 2;

  typedef enum logic [0:0] {
    MEM_IDLE,
    MEM_WAIT
  } mem_state_e;

  typedef struct packed {
    logic                   valid;
    logic                   reg_write;
    logic [REG_ID_BITS-1:0] write_reg;
    logic                   mem_read;
    logic                   mem_write;
    logic [WORD_BITS-1:0]   alu_result;
    logic [WORD_BITS-1:0]   store_data;
  } pipe_entry_t;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory handshake controller: tracks the outstanding access, drives the
// read/write strobes and the upstream stall.
// Optional MEM_WB_TIMEOUT_EN: abort an access after TimeoutCycles un-acked
// WAIT cycles and raise a sticky error flag.
module mem_access_fsm
  import tsc_pipe_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic new_mem_op_i,  // EX holds a valid load/store
  input  logic mem_read_i,    // current MEM entry is a load
  input  logic mem_write_i,   // current MEM entry is a store
  input  logic d_ack_i,
  output logic in_wait_o,
  output logic d_read_o,
  output logic d_write_o,
  output logic mem_stall_o,
  output logic complete_o,
  output logic timeout_o,
  output logic mem_error_o
);

  mem_state_e state_q, state_d;
  logic       timeout;

`ifdef MEM_WB_TIMEOUT_EN
  localparam int unsigned CntBits = $clog2(TimeoutCycles + 1);

  logic [CntBits-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;

  // Count un-acked WAIT cycles; fire on the last allowed one.
  always_comb begin
    cnt_d   = '0;
    err_d   = err_q;
    timeout = 1'b0;
    if (state_q == MEM_WAIT && !d_ack_i) begin
      if (cnt_q == CntBits'(TimeoutCycles - 1)) begin
        timeout = 1'b1;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign mem_error_o = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TimeoutCycles;
  assign timeout            = 1'b0;
  assign mem_error_o        = 1'b0;
`endif

  // Next state: a newly latched memory op always enters WAIT, including on the
  // ack edge of the previous one, so back-to-back accesses have no idle gap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MEM_IDLE: if (new_mem_op_i) state_d = MEM_WAIT;
      MEM_WAIT: begin
        if (d_ack_i) begin
          state_d = new_mem_op_i ? MEM_WAIT : MEM_IDLE;
        end else if (timeout) begin
          state_d = MEM_IDLE;
        end
      end
    endcase
  end

  // State register; async reset drops the strobes immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= MEM_IDLE;
    else         state_q <= state_d;
  end

  assign in_wait_o   = (state_q == MEM_WAIT);
  assign d_read_o    = in_wait_o & mem_read_i;
  assign d_write_o   = in_wait_o & mem_write_i;
  assign mem_stall_o = in_wait_o & ~d_ack_i;
  assign complete_o  = in_wait_o & d_ack_i;
  assign timeout_o   = timeout;

endmodule

// File: rtl/mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline latches for the TSC CPU with the data-memory
// handshake. MEM-stage forwarding outputs come straight from the EX/MEM latch;
// WB-stage outputs are registered.
// Optional MEM_WB_TIMEOUT_EN: aborted accesses are dropped and mem_error set.
module mem_wb_pipe #(
  parameter int unsigned WORD_BITS      = 16,
  parameter int unsigned REG_ID_BITS    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ex_valid,
  input  logic                   ex_reg_write,
  input  logic [REG_ID_BITS-1:0] ex_write_reg,
  input  logic                   ex_mem_read,
  input  logic                   ex_mem_write,
  input  logic [WORD_BITS-1:0]   ex_alu_result,
  input  logic [WORD_BITS-1:0]   ex_store_data,
  output logic                   mem_stall,
  output logic [WORD_BITS-1:0]   d_addr,
  output logic                   d_readM,
  output logic                   d_writeM,
  output logic [WORD_BITS-1:0]   d_data_out,
  input  logic [WORD_BITS-1:0]   d_data_in,
  input  logic                   d_ack,
  output logic                   reg_write_mem,
  output logic [REG_ID_BITS-1:0] write_reg_mem,
  output logic                   mem_is_load,
  output logic [WORD_BITS-1:0]   fwd_data_mem,
  output logic                   reg_write_wb,
  output logic [REG_ID_BITS-1:0] write_reg_wb,
  output logic [WORD_BITS-1:0]   wb_data,
  output logic                   mem_error
);
  import tsc_pipe_pkg::*;

  pipe_entry_t mem_q, mem_d;

  logic                   in_wait, wait_done, timeout, new_mem_op, entry_done;
  logic                   reg_write_wb_q, reg_write_wb_d;
  logic [REG_ID_BITS-1:0] write_reg_wb_q, write_reg_wb_d;
  logic [WORD_BITS-1:0]   wb_data_q, wb_data_d;

  assign new_mem_op = ex_valid & (ex_mem_read | ex_mem_write);

  mem_access_fsm #(
    .TimeoutCycles (TIMEOUT_CYCLES)
  ) u_fsm (
    .clk_i        (clk),
    .rst_ni       (reset_n),
    .new_mem_op_i (new_mem_op),
    .mem_read_i   (mem_q.mem_read),
    .mem_write_i  (mem_q.mem_write),
    .d_ack_i      (d_ack),
    .in_wait_o    (in_wait),
    .d_read_o     (d_readM),
    .d_write_o    (d_writeM),
    .mem_stall_o  (mem_stall),
    .complete_o   (wait_done),
    .timeout_o    (timeout),
    .mem_error_o  (mem_error)
  );

  // EX/MEM next entry: hold while stalled, bubble on invalid EX or timeout.
  always_comb begin
    mem_d = mem_q;
    if (timeout) begin
      mem_d = '0;
    end else if (!mem_stall) begin
      mem_d = '0;
      if (ex_valid) begin
        mem_d.valid      = 1'b1;
        mem_d.reg_write  = ex_reg_write & ~ex_mem_write;  // stores never write RF
        mem_d.write_reg  = ex_write_reg;
        mem_d.mem_read   = ex_mem_read;
        mem_d.mem_write  = ex_mem_write;
        mem_d.alu_result = ex_alu_result;
        mem_d.store_data = ex_store_data;
      end
    end
  end

  // MEM/WB next entry: take the MEM entry only on the cycle it completes.
  always_comb begin
    entry_done     = (mem_q.valid & ~mem_q.mem_read & ~mem_q.mem_write) | wait_done;
    reg_write_wb_d = entry_done & mem_q.reg_write;
    write_reg_wb_d = write_reg_wb_q;
    wb_data_d      = wb_data_q;
    if (entry_done) begin
      write_reg_wb_d = mem_q.write_reg;
      wb_data_d      = mem_q.mem_read ? d_data_in : mem_q.alu_result;
    end
  end

  // Pipeline latch registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q          <= '0;
      reg_write_wb_q <= 1'b0;
      write_reg_wb_q <= '0;
      wb_data_q      <= '0;
    end else begin
      mem_q          <= mem_d;
      reg_write_wb_q <= reg_write_wb_d;
      write_reg_wb_q <= write_reg_wb_d;
      wb_data_q      <= wb_data_d;
    end
  end

  assign reg_write_mem = mem_q.valid & mem_q.reg_write;
  assign write_reg_mem = mem_q.write_reg;
  assign mem_is_load   = mem_q.valid & mem_q.mem_read;
  assign fwd_data_mem  = mem_q.alu_result;

  assign d_addr     = in_wait ? mem_q.alu_result : '0;
  assign d_data_out = in_wait ? mem_q.store_data : '0;

  assign reg_write_wb = reg_write_wb_q;
  assign write_reg_wb = write_reg_wb_q;
  assign wb_data      = wb_data_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed self-checking bench for mem_wb_pipe.
// Timeout scenario is compiled only when MEM_WB_TIMEOUT_EN is defined.
module tb_mem_wb_pipe;

  logic        clk;
  logic        reset_n;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [1:0]  ex_write_reg;
  logic [15:0] ex_alu_result, ex_store_data;
  logic        mem_stall, d_readM, d_writeM;
  logic [15:0] d_addr, d_data_out, d_data_in;
  logic        d_ack;
  logic        reg_write_mem, mem_is_load, reg_write_wb, mem_error;
  logic [1:0]  write_reg_mem, write_reg_wb;
  logic [15:0] fwd_data_mem, wb_data;

  int passes = 0;
  int checks = 0;

  mem_wb_pipe dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_write_reg  (ex_write_reg),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .mem_stall     (mem_stall),
    .d_addr        (d_addr),
    .d_readM       (d_readM),
    .d_writeM      (d_writeM),
    .d_data_out    (d_data_out),
    .d_data_in     (d_data_in),
    .d_ack         (d_ack),
    .reg_write_mem (reg_write_mem),
    .write_reg_mem (write_reg_mem),
    .mem_is_load   (mem_is_load),
    .fwd_data_mem  (fwd_data_mem),
    .reg_write_wb  (reg_write_wb),
    .write_reg_wb  (write_reg_wb),
    .wb_data       (wb_data),
    .mem_error     (mem_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic rw, input logic [1:0] wr, input logic mr,
                          input logic mw, input logic [15:0] alu, input logic [15:0] sd);
    ex_valid      = v;
    ex_reg_write  = rw;
    ex_write_reg  = wr;
    ex_mem_read   = mr;
    ex_mem_write  = mw;
    ex_alu_result = alu;
    ex_store_data = sd;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    d_ack     = 1'b1;
    d_data_in = 16'hFFFF;
    drive_ex(1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 16'hABCD, 16'h5A5A);
    tick();
    tick();
    checks++;
    if ({mem_stall, d_readM, d_writeM, reg_write_mem, mem_is_load, reg_write_wb, mem_error}
        !== 7'b0)
      $display("FAIL reset_flags: got %b want 0000000", {mem_stall, d_readM, d_writeM,
               reg_write_mem, mem_is_load, reg_write_wb, mem_error});
    else passes++;
    checks++;
    if ({d_addr, d_data_out} !== 32'h0)
      $display("FAIL reset_dbus: got %h want 0", {d_addr, d_data_out});
    else passes++;
    checks++;
    if ({fwd_data_mem, wb_data, write_reg_mem, write_reg_wb} !== 36'h0)
      $display("FAIL reset_data: got %h want 0", {fwd_data_mem, wb_data, write_reg_mem,
               write_reg_wb});
    else passes++;
    reset_n = 1'b1;
    d_ack   = 1'b0;
    drive_ex(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    checks++;
    if (reg_write_mem !== 1'b0) $display("FAIL post_reset_rw_mem: got %b want 0", reg_write_mem);
    else passes++;
    tick();
    checks++;
    if (reg_write_wb !== 1'b0) $display("FAIL post_reset_rw_wb: got %b want 0", reg_write_wb);
    else passes++;
  endtask

  task automatic test_alu();
    drive_ex(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 16'h1234, 16'h0);
    tick();
    drive_ex(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    checks++;
    if ({reg_write_mem, write_reg_mem, fwd_data_mem, mem_stall} !== {1'b1, 2'd2, 16'h1234, 1'b0})
      $display("FAIL alu_mem: got rw=%b wr=%0d fwd=%h stall=%b want 1 2 1234 0",
               reg_write_mem, write_reg_mem, fwd_data_mem, mem_stall);
    else passes++;
    tick();
    checks++;
    if ({reg_write_wb, write_reg_wb, wb_data, mem_stall} !== {1'b1, 2'd2, 16'h1234, 1'b0})
      $display("FAIL alu_wb: got rw=%b wr=%0d data=%h stall=%b want 1 2 1234 0",
               reg_write_wb, write_reg_wb, wb_data, mem_stall);
    else passes++;
  endtask

  task automatic test_load_late_ack();
    d_ack     = 1'b0;
    d_data_in = 16'h0000;
    drive_ex(1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 16'h0040, 16'h0);
    tick();
    drive_ex(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({d_readM, d_writeM, d_addr, mem_stall, mem_is_load} !== {2'b10, 16'h0040, 2'b11})
        $display("FAIL load_wait%0d: got rd=%b wr=%b addr=%h stall=%b ld=%b want 1 0 0040 1 1",
                 i, d_readM, d_writeM, d_addr, mem_stall, mem_is_load);
      else passes++;
      tick();
      checks++;
      if (reg_write_wb !== 1'b0) $display("FAIL load_wb_bubble%0d: got %b want 0", i, reg_write_wb);
      else passes++;
    end
    d_ack     = 1'b1;
    d_data_in = 16'hBEEF;
    #1;
    checks++;
    if ({d_readM, d_addr, mem_stall} !== {1'b1, 16'h0040, 1'b0})
      $display("FAIL load_ack_cycle: got rd=%b addr=%h stall=%b want 1 0040 0",
               d_readM, d_addr, mem_stall);
    else passes++;
    tick();
    d_ack = 1'b0;
    #1;
    checks++;
    if ({reg_write_wb, write_reg_wb, wb_data, d_readM} !== {1'b1, 2'd1, 16'hBEEF, 1'b0})
      $display("FAIL load_wb: got rw=%b wr=%0d data=%h rd=%b want 1 1 beef 0",
               reg_write_wb, write_reg_wb, wb_data, d_readM);
    else passes++;
  endtask

  task automatic test_back_to_back();
    d_ack     = 1'b1;
    d_data_in = 16'h00AA;
    drive_ex(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 16'h0010, 16'h00AA);
    tick();
    drive_ex(1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 16'h0010, 16'h0);
    #1;
    checks++;
    if ({d_writeM, d_readM, d_addr, d_data_out, mem_stall}
        !== {2'b10, 16'h0010, 16'h00AA, 1'b0})
      $display("FAIL b2b_store: got wr=%b rd=%b addr=%h dout=%h stall=%b want 1 0 0010 00aa 0",
               d_writeM, d_readM, d_addr, d_data_out, mem_stall);
    else passes++;
    tick();
    drive_ex(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    checks++;
    if ({d_readM, d_writeM, d_addr, mem_stall, mem_is_load} !== {2'b10, 16'h0010, 2'b01})
      $display("FAIL b2b_load: got rd=%b wr=%b addr=%h stall=%b ld=%b want 1 0 0010 0 1",
               d_readM, d_writeM, d_addr, mem_stall, mem_is_load);
    else passes++;
    checks++;
    if (reg_write_wb !== 1'b0) $display("FAIL b2b_store_wb: got %b want 0", reg_write_wb);
    else passes++;
    tick();
    d_ack = 1'b0;
    #1;
    checks++;
    if ({reg_write_wb, write_reg_wb, wb_data, d_readM} !== {1'b1, 2'd3, 16'h00AA, 1'b0})
      $display("FAIL b2b_load_wb: got rw=%b wr=%0d data=%h rd=%b want 1 3 00aa 0",
               reg_write_wb, write_reg_wb, wb_data, d_readM);
    else passes++;
  endtask

`ifdef MEM_WB_TIMEOUT_EN
  task automatic test_timeout();
    d_ack = 1'b0;
    drive_ex(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 16'h0030, 16'h0);
    tick();
    drive_ex(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 15; i++) begin
      #1;
      checks++;
      if ({d_readM, mem_stall, mem_error} !== 3'b110)
        $display("FAIL to_wait%0d: got rd=%b stall=%b err=%b want 1 1 0",
                 i, d_readM, mem_stall, mem_error);
      else passes++;
      tick();
    end
    checks++;
    if ({d_readM, mem_stall, mem_error, reg_write_wb, reg_write_mem} !== 5'b00100)
      $display("FAIL to_abort: got rd=%b stall=%b err=%b rw_wb=%b rw_mem=%b want 0 0 1 0 0",
               d_readM, mem_stall, mem_error, reg_write_wb, reg_write_mem);
    else passes++;
    tick();
    tick();
    checks++;
    if ({mem_error, reg_write_wb} !== 2'b10)
      $display("FAIL to_sticky: got err=%b rw_wb=%b want 1 0", mem_error, reg_write_wb);
    else passes++;
  endtask
`else
  task automatic test_no_timeout();
    d_ack = 1'b0;
    drive_ex(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 16'h0030, 16'h0);
    tick();
    drive_ex(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if ({d_readM, mem_stall, mem_error, d_addr} !== {3'b110, 16'h0030})
      $display("FAIL no_to_wait: got rd=%b stall=%b err=%b addr=%h want 1 1 0 0030",
               d_readM, mem_stall, mem_error, d_addr);
    else passes++;
    d_ack     = 1'b1;
    d_data_in = 16'h5555;
    tick();
    d_ack = 1'b0;
    #1;
    checks++;
    if ({reg_write_wb, write_reg_wb, wb_data} !== {1'b1, 2'd2, 16'h5555})
      $display("FAIL no_to_wb: got rw=%b wr=%0d data=%h want 1 2 5555",
               reg_write_wb, write_reg_wb, wb_data);
    else passes++;
  endtask
`endif

  task automatic test_reset_in_wait();
    d_ack = 1'b0;
    drive_ex(1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 16'h0020, 16'h0);
    tick();
    drive_ex(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    checks++;
    if (d_readM !== 1'b1) $display("FAIL rw_pre_reset: got rd=%b want 1", d_readM);
    else passes++;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({d_readM, mem_stall, mem_is_load, mem_error} !== 4'b0000)
      $display("FAIL rw_async_drop: got rd=%b stall=%b ld=%b err=%b want 0 0 0 0",
               d_readM, mem_stall, mem_is_load, mem_error);
    else passes++;
    tick();
    reset_n = 1'b1;
    tick();
    d_ack     = 1'b1;
    d_data_in = 16'h7777;
    #1;
    checks++;
    if ({d_readM, mem_stall} !== 2'b00)
      $display("FAIL rw_late_ack: got rd=%b stall=%b want 0 0", d_readM, mem_stall);
    else passes++;
    tick();
    d_ack = 1'b0;
    #1;
    checks++;
    if ({reg_write_wb, wb_data, d_readM} !== {1'b0, 16'h0000, 1'b0})
      $display("FAIL rw_after: got rw_wb=%b data=%h rd=%b want 0 0000 0",
               reg_write_wb, wb_data, d_readM);
    else passes++;
  endtask

  initial begin
    reset_n   = 1'b0;
    d_ack     = 1'b0;
    d_data_in = 16'h0;
    drive_ex(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0);
    test_reset();
    test_alu();
    test_load_late_ack();
    test_back_to_back();
`ifdef MEM_WB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
